bin2bcd_seq_ctrl: RTL
=====================

// Module: bin2bcd_seq_ctrl
// PURPOSE
//   Sequential binary-to-BCD converter: runs the shift-and-add-3 (double-dabble) algorithm over
//   WIDTH input bits, time-sharing a single add_3 correction unit across all DIGITS BCD digits.
//   Sits between a binary source (counter/ALU result) and the 7-segment display driver;
//   start/busy/done handshake toward the source.
// PARAMETERS
//   WIDTH   8  binary input width in bits, >= 1
//   DIGITS  3  BCD output digits; must satisfy 10**DIGITS > 2**WIDTH-1 (elaboration-time check, $error)
// PORTS
//   clk      in   1          single clock, all state on rising edge
//   rst_n    in   1          reset, asynchronous assert, active-low
//   start    in   1          conversion request; sampled only in IDLE
//   bin_in   in   WIDTH      binary operand; captured on the edge that accepts start
//   busy     out  1          high while in CORR or SHIFT
//   done     out  1          one-cycle pulse: bcd_out just updated
//   bcd_out  out  4*DIGITS   result, digit i = bcd_out[4i+3:4i], digit 0 = units
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, busy=0, done=0, bcd_out=0, all working regs 0.
//     Reset mid-conversion aborts; no done pulse; the conversion is lost.
//   Registers: bin_sh[WIDTH], bcd_wk[4*DIGITS], bit_cnt, dig_idx; all outputs registered.
//   FSM states: IDLE, CORR, SHIFT, DONE.
//   IDLE:  start=1 -> bin_sh<=bin_in, bcd_wk<=0, bit_cnt<=WIDTH, dig_idx<=0, -> CORR.
//          start=0 -> stay.
//   CORR:  shared add_3 input = bcd_wk digit[dig_idx]; its output written back to that digit.
//          dig_idx==DIGITS-1 -> dig_idx<=0, -> SHIFT; else dig_idx++ (one digit per cycle).
//   SHIFT: {bcd_wk,bin_sh} <<= 1 (MSB of bin_sh enters bcd_wk[0]; bin_sh LSB filled with 0);
//          bit_cnt--; if bit_cnt was 1 -> DONE else -> CORR.
//   DONE:  bcd_out<=bcd_wk on entry edge; done=1 for exactly this cycle; -> IDLE.
//   Correcting before the first shift is harmless: all digits are 0 and map to 0.
//   Latency: accept edge at cycle 0 -> done high in cycle WIDTH*(DIGITS+1)+1
//     (33 for defaults); next start can be accepted in the cycle after done (back-to-back).
//   start while busy or done: ignored, not queued; bin_in changes outside accept edge ignored.
//   bcd_out holds the last result until the next completed conversion (stable during busy).
//   Invariant: digit fed to add_3 is always 0..9; the add_3 default arm (10..15 -> 0) is
//     unreachable; the bench asserts this.
//   Widths: bit_cnt $clog2(WIDTH+1) bits, dig_idx $clog2(DIGITS) bits (min 1); no wrap beyond
//     bounds.
// STRUCTURE
//   Shared package bin2bcd_pkg: FSM state encoding (2-bit localparams IDLE/CORR/SHIFT/DONE),
//     BCD_DIGIT_W=4.
//   One sub-module instance: existing add_3 (A[3:0] -> S[3:0]), single copy, input mux and
//     write-back demux on dig_idx.
//   Everything else (FSM, counters, shift regs) stays in this module.
// TESTING
//   1 bin_in=8'd255, start 1 cycle -> busy next cycle, done in cycle 33, bcd_out=12'h255.
//   2 bin_in=0, then 99, then 128 back-to-back (start asserted in the cycle after each done)
//     -> 12'h000, 12'h099, 12'h128; no idle gap needed.
//   3 start=1 held and bin_in toggled during busy -> exactly one done, result of the value
//     captured at accept (e.g. 173 -> 12'h173).
//   4 rst_n pulled low at cycle 10 of a conversion of 200 -> busy=0, done=0, bcd_out=0 at
//     once; new start of 42 after release -> 12'h042.
//   5 exhaustive 0..255 vs reference model; assert add_3 input <= 9 each CORR cycle and done
//     width = 1.
//   6 WIDTH=4, DIGITS=2: bin_in=4'd15 -> bcd_out=8'h15, done in cycle 4*3+1=13.

Source files
------------

// File: rtl/bin2bcd_seq_ctrl_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and an elaboration-time helper.
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CORR  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // 10**n, used only for parameter sanity checking at elaboration.
    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// Handshake/data bundle between a binary source and the converter.
// Handshake: the source raises start with bin_in valid; the converter accepts
// it only on an edge where it is idle (busy=0, done=0). busy is high for the
// whole conversion, done pulses for one cycle when bcd_out has just updated.
// start seen while busy or done is dropped, not queued. The dbg_* signals
// expose the FSM state and the shared add_3 operand for checkers.
interface bin2bcd_seq_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    import bin2bcd_pkg::*;

    logic                            start;
    logic [WIDTH-1:0]                bin_in;
    logic                            busy;
    logic                            done;
    logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out;
    state_e                          dbg_state;
    logic [BCD_DIGIT_W-1:0]          dbg_add3_in;

    // Source side
    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, dbg_state, dbg_add3_in
    );

    // Converter side
    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, dbg_state, dbg_add3_in
    );

endinterface

// File: rtl/bin2bcd_seq_ctrl_add3.sv
// Double-dabble correction for one BCD digit: digits 5..9 get +3 so that the
// following left shift carries correctly into the next digit. Inputs above 9
// never occur in a correct conversion and map to 0.
module add_3 (
    input  logic [3:0] A,
    output logic [3:0] S
);

    // Combinational correction table
    always_comb begin
        S = 4'd0;
        case (A)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: S = A;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: S = A + 4'd3;
            default:                      S = 4'd0;
        endcase
    end

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter. One bit per SHIFT step; before each
// shift every digit is corrected in turn through a single shared add_3, one
// digit per CORR cycle. Conversion takes WIDTH*(DIGITS+1) busy cycles plus a
// one-cycle DONE state that publishes the result.
module bin2bcd_seq_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin2bcd_seq_ctrl_if.slave    bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam longint MAX_BIN = (longint'(1) << WIDTH) - 1;

    // Reject parameter sets whose result cannot fit in DIGITS digits.
    if (WIDTH < 1 || pow10(DIGITS) <= MAX_BIN) begin : g_param_check
        $error("bin2bcd_seq_ctrl: need WIDTH >= 1 and 10**DIGITS > 2**WIDTH-1");
    end

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        bin_sh_q, bin_sh_d;
    logic [BCD_W-1:0]        bcd_wk_q, bcd_wk_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DIG_W-1:0]        dig_idx_q, dig_idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [BCD_W-1:0]        bcd_out_q, bcd_out_d;

    logic [BCD_DIGIT_W-1:0]  add_in;
    logic [BCD_DIGIT_W-1:0]  add_out;

    // Shared correction unit input mux: select the digit addressed by dig_idx
    always_comb begin
        add_in = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx_q == DIG_W'(i)) begin
                add_in = bcd_wk_q[BCD_DIGIT_W*i +: BCD_DIGIT_W];
            end
        end
    end

    add_3 u_add3 (
        .A (add_in),
        .S (add_out)
    );

    // Next-state logic, datapath updates and registered-output precompute
    always_comb begin
        state_d   = state_q;
        bin_sh_d  = bin_sh_q;
        bcd_wk_d  = bcd_wk_q;
        bit_cnt_d = bit_cnt_q;
        dig_idx_d = dig_idx_q;
        bcd_out_d = bcd_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_sh_d  = bus.bin_in;
                    bcd_wk_d  = '0;
                    bit_cnt_d = CNT_W'(WIDTH);
                    dig_idx_d = '0;
                    state_d   = CORR;
                end
            end
            CORR: begin
                // Write-back demux for the shared add_3 result
                for (int i = 0; i < DIGITS; i++) begin
                    if (dig_idx_q == DIG_W'(i)) begin
                        bcd_wk_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] = add_out;
                    end
                end
                if (dig_idx_q == DIG_W'(DIGITS - 1)) begin
                    dig_idx_d = '0;
                    state_d   = SHIFT;
                end else begin
                    dig_idx_d = dig_idx_q + 1'b1;
                end
            end
            SHIFT: begin
                {bcd_wk_d, bin_sh_d} = {bcd_wk_q[BCD_W-2:0], bin_sh_q, 1'b0};
                bit_cnt_d = bit_cnt_q - 1'b1;
                if (bit_cnt_q == CNT_W'(1)) begin
                    bcd_out_d = bcd_wk_d;
                    state_d   = DONE;
                end else begin
                    state_d   = CORR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CORR) || (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_sh_q  <= '0;
            bcd_wk_q  <= '0;
            bit_cnt_q <= '0;
            dig_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bin_sh_q  <= bin_sh_d;
            bcd_wk_q  <= bcd_wk_d;
            bit_cnt_q <= bit_cnt_d;
            dig_idx_q <= dig_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_out_q <= bcd_out_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.bcd_out     = bcd_out_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_add3_in = add_in;

endmodule
